// File: rtl/button_conditioner_if.sv
// Raw board pins in, conditioned stopwatch controls out.
// The slave side is the conditioner; the master side drives pins and observes controls.
interface button_conditioner_if;
  logic btn_pause;
  logic btn_clear;
  logic sw_adj;
  logic sw_sel;
  logic paused;
  logic clear_pulse;
  logic adj;
  logic sel;

  modport master (
    output btn_pause, btn_clear, sw_adj, sw_sel,
    input  paused, clear_pulse, adj, sel
  );

  modport slave (
    input  btn_pause, btn_clear, sw_adj, sw_sel,
    output paused, clear_pulse, adj, sel
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise and debounce two buttons and two switches; a steady raw change reaches the outputs
// DEBOUNCE_CYCLES+2 edges after it is first sampled. No backpressure: outputs are free-running levels/pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  io
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int CH_PAUSE = 0;
  localparam int CH_CLEAR = 1;
  localparam int CH_ADJ   = 2;
  localparam int CH_SEL   = 3;

  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       accept;
  logic [CNT_W-1:0] cnt [4];
  logic             pause_rise;
  logic             clear_rise;
  logic             paused_q;
  logic             clear_pulse_q;

  assign raw = {io.sw_sel, io.sw_adj, io.btn_clear, io.btn_pause};

  // A channel accepts when its synchronised value has disagreed with the stable value long enough.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign pause_rise = accept[CH_PAUSE] & sync2[CH_PAUSE];
  assign clear_rise = accept[CH_CLEAR] & sync2[CH_CLEAR];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      stable        <= '0;
      paused_q      <= 1'b0;
      clear_pulse_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]    <= '0;
          stable[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      clear_pulse_q <= clear_rise;
      // Clear has priority over a pause toggle landing on the same edge.
      if (clear_rise) begin
        paused_q <= 1'b0;
      end else if (pause_rise) begin
        paused_q <= ~paused_q;
      end
    end
  end

  assign io.paused      = paused_q;
  assign io.clear_pulse = clear_pulse_q;
  assign io.adj         = stable[CH_ADJ];
  assign io.sel         = stable[CH_SEL];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed test-plan steps followed by random pin activity, all checked against a history-window model.
module tb_button_conditioner;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  button_conditioner_if bif ();

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  always #5 clk = ~clk;

  // Model: raw pin values per edge; a channel flips once the last D synchronised samples all oppose it.
  logic [3:0] raw_hist [$];
  logic [3:0] mq      = '0;
  logic       mpaused = 1'b0;
  logic       mpulse  = 1'b0;

  function automatic logic raw_at(input int idx, input int ch);
    if (idx < 0) return 1'b0;
    return raw_hist[idx][ch];
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rs);
    logic [3:0] new_q;
    logic       ok;
    int         n;
    if (rs) begin
      raw_hist.push_back(4'b0);
      if (raw_hist.size() >= 2) raw_hist[raw_hist.size()-2] = 4'b0;
      mq      = '0;
      mpaused = 1'b0;
      mpulse  = 1'b0;
    end else begin
      raw_hist.push_back(r);
      n     = raw_hist.size() - 1;
      new_q = mq;
      for (int ch = 0; ch < 4; ch++) begin
        ok = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (raw_at(n - 2 - j, ch) == mq[ch]) ok = 1'b0;
        end
        if (ok) new_q[ch] = ~mq[ch];
      end
      mpulse = new_q[1] & ~mq[1];
      if (new_q[1] & ~mq[1]) mpaused = 1'b0;
      else if (new_q[0] & ~mq[0]) mpaused = ~mpaused;
      mq = new_q;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // r bits: 0 pause, 1 clear, 2 adj, 3 sel.
  task automatic step(input logic [3:0] r, input logic rs);
    bif.btn_pause = r[0];
    bif.btn_clear = r[1];
    bif.sw_adj    = r[2];
    bif.sw_sel    = r[3];
    rst           = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    chk("model_paused", bif.paused,      mpaused);
    chk("model_clear",  bif.clear_pulse, mpulse);
    chk("model_adj",    bif.adj,         mq[2]);
    chk("model_sel",    bif.sel,         mq[3]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, bif.paused | bif.clear_pulse | bif.adj | bif.sel, 1'b0);
  endtask

  logic [3:0] cur;

  initial begin
    bif.btn_pause = 1'b0;
    bif.btn_clear = 1'b0;
    bif.sw_adj    = 1'b0;
    bif.sw_sel    = 1'b0;

    // 1. Reset and idle.
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk("rst_paused", bif.paused, 1'b0);
    chk("rst_clear",  bif.clear_pulse, 1'b0);
    chk("rst_adj",    bif.adj, 1'b0);
    chk("rst_sel",    bif.sel, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 1'b0);
      chk_all_zero("idle_zero");
    end

    // 2. Clean press, release, second press.
    for (int i = 1; i <= 6; i++) begin
      step(4'b0001, 1'b0);
      chk("press1_paused", bif.paused, (i == 6) ? 1'b1 : 1'b0);
      chk("press1_clear",  bif.clear_pulse, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, 1'b0);
      chk("release1_paused", bif.paused, 1'b1);
    end
    for (int i = 1; i <= 6; i++) begin
      step(4'b0001, 1'b0);
      chk("press2_paused", bif.paused, (i == 6) ? 1'b0 : 1'b1);
    end
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0);

    // 3. Bounce 1,0,1,1,0,1 then hold.
    step(4'b0001, 1'b0); chk("bounce_paused", bif.paused, 1'b0);
    step(4'b0000, 1'b0); chk("bounce_paused", bif.paused, 1'b0);
    step(4'b0001, 1'b0); chk("bounce_paused", bif.paused, 1'b0);
    step(4'b0001, 1'b0); chk("bounce_paused", bif.paused, 1'b0);
    step(4'b0000, 1'b0); chk("bounce_paused", bif.paused, 1'b0);
    step(4'b0001, 1'b0); chk("bounce_paused", bif.paused, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      step(4'b0001, 1'b0);
      chk("bounce_hold_paused", bif.paused, (i >= 6) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0);

    // 4. Clear while paused; long hold gives a single pulse.
    for (int i = 1; i <= 20; i++) begin
      step(4'b0010, 1'b0);
      chk("clr_pulse",  bif.clear_pulse, (i == 6) ? 1'b1 : 1'b0);
      chk("clr_paused", bif.paused, (i < 6) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0);

    // 5. Simultaneous pause and clear.
    for (int i = 1; i <= 8; i++) begin
      step(4'b0011, 1'b0);
      chk("sim_pulse",  bif.clear_pulse, (i == 6) ? 1'b1 : 1'b0);
      chk("sim_paused", bif.paused, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0);

    // 6. Short adj glitch, then sel held through a reset.
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b0);
      chk("adj_glitch", bif.adj, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 1'b0);
      chk("adj_glitch", bif.adj, 1'b0);
    end
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    chk("sel_in_rst", bif.sel, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(4'b1000, 1'b0);
      chk("sel_after_rst", bif.sel, (i >= 6) ? 1'b1 : 1'b0);
    end

    // Random pin activity with occasional resets.
    cur = 4'b1000;
    for (int i = 0; i < 2000; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(7) == 0) cur[ch] = ~cur[ch];
      end
      step(cur, ($urandom_range(199) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
